// File: rtl/pulse_meter.sv
// Pulse width/timestamp meter: emits one AXI4-Stream record {width, rise_ts} per completed
// high pulse on din, through a 2-entry buffer that drops and counts records when full.
module pulse_meter #(
    parameter int unsigned CNTR_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      din,
    output logic [2*CNTR_WIDTH-1:0]   m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      overflow,
    output logic [CNTR_WIDTH-1:0]     drop_cnt,
    output logic [CNTR_WIDTH-1:0]     ts
);

    localparam logic [CNTR_WIDTH-1:0] MaxVal = '1;
    localparam logic [CNTR_WIDTH-1:0] One    = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StHigh} state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic                    r_din_d;
    logic [CNTR_WIDTH-1:0]   r_ts;
    logic [CNTR_WIDTH-1:0]   r_rise_ts;
    logic [CNTR_WIDTH-1:0]   w_rise_ts_nxt;
    logic [CNTR_WIDTH-1:0]   r_width;
    logic [CNTR_WIDTH-1:0]   w_width_nxt;
    logic [2*CNTR_WIDTH-1:0] r_buf0;
    logic [2*CNTR_WIDTH-1:0] r_buf1;
    logic [2*CNTR_WIDTH-1:0] w_buf0_nxt;
    logic [2*CNTR_WIDTH-1:0] w_buf1_nxt;
    logic [1:0]              r_cnt;
    logic [1:0]              w_cnt_nxt;
    logic                    r_overflow;
    logic [CNTR_WIDTH-1:0]   r_drop_cnt;

    logic                    w_rise;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_accept;
    logic                    w_drop;
    logic [2*CNTR_WIDTH-1:0] w_record;

    assign w_rise   = din & ~r_din_d;
    assign w_pop    = m_axis_tvalid & m_axis_tready;
    assign w_accept = w_push & ((r_cnt != 2'd2) | w_pop);
    assign w_drop   = w_push & ~w_accept;
    assign w_record = {r_width, r_rise_ts};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= StIdle;
            r_din_d   <= 1'b0;
            r_ts      <= '0;
            r_rise_ts <= '0;
            r_width   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_din_d   <= din;
            r_ts      <= r_ts + One;
            r_rise_ts <= w_rise_ts_nxt;
            r_width   <= w_width_nxt;
        end
    end

    // In StHigh, din low always means a falling edge since din_d was high.
    always_comb begin
        w_state_nxt   = r_state;
        w_rise_ts_nxt = r_rise_ts;
        w_width_nxt   = r_width;
        w_push        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_state_nxt   = StHigh;
                    w_rise_ts_nxt = r_ts;
                    w_width_nxt   = One;
                end
            end
            StHigh: begin
                if (din) begin
                    if (r_width != MaxVal) w_width_nxt = r_width + One;
                end else begin
                    w_state_nxt = StIdle;
                    w_push      = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Pop shifts the second entry to the head before the push picks its slot.
    always_comb begin
        w_buf0_nxt = r_buf0;
        w_buf1_nxt = r_buf1;
        w_cnt_nxt  = r_cnt;
        if (w_pop) begin
            w_buf0_nxt = r_buf1;
            w_cnt_nxt  = r_cnt - 2'd1;
        end
        if (w_accept) begin
            if (w_cnt_nxt == 2'd0) w_buf0_nxt = w_record;
            else                   w_buf1_nxt = w_record;
            w_cnt_nxt = w_cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_cnt      <= 2'd0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_buf0 <= w_buf0_nxt;
            r_buf1 <= w_buf1_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != MaxVal) r_drop_cnt <= r_drop_cnt + One;
            end
        end
    end

    assign m_axis_tdata  = r_buf0;
    assign m_axis_tvalid = (r_cnt != 2'd0);
    assign overflow      = r_overflow;
    assign drop_cnt      = r_drop_cnt;
    assign ts            = r_ts;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: a 32-bit instance for the main scenarios and an
// 8-bit instance for timestamp wrap and width saturation.
module tb_pulse_meter;

    logic        aclk;
    logic        aresetn;
    logic        din;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overflow;
    logic [31:0] drop_cnt;
    logic [31:0] ts;

    logic        aresetn8;
    logic        din8;
    logic [15:0] tdata8;
    logic        tvalid8;
    logic        tready8;
    logic        overflow8;
    logic [7:0]  drop_cnt8;
    logic [7:0]  ts8;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] rec_q[$];

    pulse_meter #(.CNTR_WIDTH(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .din           (din),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt),
        .ts            (ts)
    );

    pulse_meter #(.CNTR_WIDTH(8)) dut8 (
        .aclk          (aclk),
        .aresetn       (aresetn8),
        .din           (din8),
        .m_axis_tdata  (tdata8),
        .m_axis_tvalid (tvalid8),
        .m_axis_tready (tready8),
        .overflow      (overflow8),
        .drop_cnt      (drop_cnt8),
        .ts            (ts8)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Capture any record handed over at the coming edge, then advance one cycle.
    task automatic cyc();
        if (m_axis_tvalid && m_axis_tready) rec_q.push_back(m_axis_tdata);
        tick();
    endtask

    // Leaves the bench in cycle 0 (ts = 0) of the 32-bit instance.
    task automatic do_reset();
        aresetn = 1'b0;
        din     = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tvalid got %0b want 0", m_axis_tvalid);
        end
        n_tests++;
        if (m_axis_tdata !== 64'd0) begin
            n_fail++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata);
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow);
        end
        n_tests++;
        if (drop_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt);
        end
        n_tests++;
        if (ts !== 32'd0) begin
            n_fail++; $display("FAIL reset_ts got %0d want 0", ts);
        end
    endtask

    task automatic test_single_pulse();
        do_reset();
        m_axis_tready = 1'b1;
        repeat (10) tick();
        din = 1'b1;
        repeat (5) tick();
        din = 1'b0;
        n_tests++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL single_c15_tvalid got %0b want 0", m_axis_tvalid);
        end
        tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b1) begin
            n_fail++; $display("FAIL single_c16_tvalid got %0b want 1", m_axis_tvalid);
        end
        n_tests++;
        if (m_axis_tdata !== {32'd5, 32'd10}) begin
            n_fail++; $display("FAIL single_tdata got %h want %h", m_axis_tdata, {32'd5, 32'd10});
        end
        tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL single_c17_tvalid got %0b want 0", m_axis_tvalid);
        end
    endtask

    // Generator-like stream: 3 cycles high, period 10.
    task automatic test_loopback();
        do_reset();
        m_axis_tready = 1'b1;
        rec_q.delete();
        for (int p = 0; p < 4; p++) begin
            din = 1'b1;
            repeat (3) cyc();
            din = 1'b0;
            repeat (7) cyc();
        end
        repeat (3) cyc();
        n_tests++;
        if (rec_q.size() !== 4) begin
            n_fail++; $display("FAIL loop_count got %0d want 4", rec_q.size());
        end
        for (int i = 0; i < rec_q.size(); i++) begin
            n_tests++;
            if (rec_q[i][63:32] !== 32'd3) begin
                n_fail++; $display("FAIL loop_width[%0d] got %0d want 3", i, rec_q[i][63:32]);
            end
            n_tests++;
            if (rec_q[i][31:0] !== 32'(10 * i)) begin
                n_fail++; $display("FAIL loop_rise_ts[%0d] got %0d want %0d", i, rec_q[i][31:0], 10 * i);
            end
            if (i > 0) begin
                n_tests++;
                if (rec_q[i][31:0] - rec_q[i-1][31:0] !== 32'd10) begin
                    n_fail++;
                    $display("FAIL loop_spacing[%0d] got %0d want 10", i,
                             rec_q[i][31:0] - rec_q[i-1][31:0]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_axis_tready = 1'b0;
        rec_q.delete();
        for (int p = 0; p < 4; p++) begin
            din = 1'b1;
            repeat (2) cyc();
            din = 1'b0;
            repeat (2) cyc();
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL bp_overflow got %0b want 1", overflow);
        end
        n_tests++;
        if (drop_cnt !== 32'd2) begin
            n_fail++; $display("FAIL bp_drop_cnt got %0d want 2", drop_cnt);
        end
        n_tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {32'd2, 32'd0}) begin
            n_fail++;
            $display("FAIL bp_head_stable got v=%0b d=%h want v=1 d=%h",
                     m_axis_tvalid, m_axis_tdata, {32'd2, 32'd0});
        end
        m_axis_tready = 1'b1;
        repeat (4) cyc();
        n_tests++;
        if (rec_q.size() !== 2) begin
            n_fail++; $display("FAIL bp_count got %0d want 2", rec_q.size());
        end else begin
            n_tests++;
            if (rec_q[0] !== {32'd2, 32'd0} || rec_q[1] !== {32'd2, 32'd4}) begin
                n_fail++; $display("FAIL bp_order got %h,%h want %h,%h", rec_q[0], rec_q[1],
                                   {32'd2, 32'd0}, {32'd2, 32'd4});
            end
        end
        n_tests++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drained_tvalid got %0b want 0", m_axis_tvalid);
        end
    endtask

    // Continues straight from test_backpressure so the reset must clear overflow/drop_cnt.
    task automatic test_reset_mid_pulse();
        m_axis_tready = 1'b1;
        din = 1'b1;
        repeat (5) tick();
        aresetn = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'd0) begin
            n_fail++; $display("FAIL mid_rst_axis got v=%0b d=%h want v=0 d=0", m_axis_tvalid, m_axis_tdata);
        end
        n_tests++;
        if (overflow !== 1'b0 || drop_cnt !== 32'd0) begin
            n_fail++; $display("FAIL mid_rst_drop got ovf=%0b cnt=%0d want 0,0", overflow, drop_cnt);
        end
        n_tests++;
        if (ts !== 32'd0) begin
            n_fail++; $display("FAIL mid_rst_ts got %0d want 0", ts);
        end
        aresetn = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL mid_partial_tvalid got %0b want 0", m_axis_tvalid);
        end
        din = 1'b0;
        tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {32'd4, 32'd0}) begin
            n_fail++; $display("FAIL mid_post_record got v=%0b d=%h want v=1 d=%h",
                               m_axis_tvalid, m_axis_tdata, {32'd4, 32'd0});
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        m_axis_tready = 1'b0;
        rec_q.delete();
        for (int p = 0; p < 2; p++) begin
            din = 1'b1;
            repeat (2) cyc();
            din = 1'b0;
            repeat (2) cyc();
        end
        din = 1'b1;
        repeat (2) cyc();
        din = 1'b0;
        m_axis_tready = 1'b1;
        cyc();
        m_axis_tready = 1'b0;
        n_tests++;
        if (drop_cnt !== 32'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL fpp_no_drop got ovf=%0b cnt=%0d want 0,0", overflow, drop_cnt);
        end
        n_tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {32'd2, 32'd4}) begin
            n_fail++; $display("FAIL fpp_head got v=%0b d=%h want v=1 d=%h",
                               m_axis_tvalid, m_axis_tdata, {32'd2, 32'd4});
        end
        m_axis_tready = 1'b1;
        repeat (4) cyc();
        n_tests++;
        if (rec_q.size() !== 3) begin
            n_fail++; $display("FAIL fpp_count got %0d want 3", rec_q.size());
        end else begin
            n_tests++;
            if (rec_q[0] !== {32'd2, 32'd0} || rec_q[1] !== {32'd2, 32'd4}
                || rec_q[2] !== {32'd2, 32'd8}) begin
                n_fail++; $display("FAIL fpp_order got %h,%h,%h want %h,%h,%h",
                                   rec_q[0], rec_q[1], rec_q[2],
                                   {32'd2, 32'd0}, {32'd2, 32'd4}, {32'd2, 32'd8});
            end
        end
    endtask

    task automatic test_wrap_saturate();
        aresetn8 = 1'b0;
        din8     = 1'b0;
        tready8  = 1'b1;
        repeat (3) tick();
        aresetn8 = 1'b1;
        repeat (250) tick();
        n_tests++;
        if (ts8 !== 8'd250) begin
            n_fail++; $display("FAIL wrap_ts250 got %0d want 250", ts8);
        end
        din8 = 1'b1;
        repeat (10) tick();
        din8 = 1'b0;
        tick();
        n_tests++;
        if (tvalid8 !== 1'b1 || tdata8 !== {8'd10, 8'd250}) begin
            n_fail++; $display("FAIL wrap_record got v=%0b d=%h want v=1 d=%h", tvalid8, tdata8,
                               {8'd10, 8'd250});
        end
        n_tests++;
        if (ts8 !== 8'd5) begin
            n_fail++; $display("FAIL wrap_ts got %0d want 5", ts8);
        end
        tick();
        din8 = 1'b1;
        repeat (300) tick();
        din8 = 1'b0;
        tick();
        n_tests++;
        if (tvalid8 !== 1'b1 || tdata8 !== {8'hff, 8'd6}) begin
            n_fail++; $display("FAIL sat_record got v=%0b d=%h want v=1 d=%h", tvalid8, tdata8,
                               {8'hff, 8'd6});
        end
    endtask

    initial begin
        aresetn       = 1'b0;
        din           = 1'b0;
        m_axis_tready = 1'b0;
        aresetn8      = 1'b0;
        din8          = 1'b0;
        tready8       = 1'b1;
        test_reset();
        test_single_pulse();
        test_loopback();
        test_backpressure();
        test_reset_mid_pulse();
        test_full_push_pop();
        test_wrap_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Measures pulses on a single-bit, same-clock input, typically the `dout` of a `pulse_generator`. For every completed high pulse it emits one AXI4-Stream record carrying the rising-edge timestamp and the pulse width in clock cycles. Records pass through a 2-entry output buffer. If a record completes while the buffer is full, the record is dropped and the drop is counted. The block sits directly downstream of the pulse generator and feeds a DMA or FIFO writer for pulse-timing readback and loopback checks.

## Interface
- `CNTR_WIDTH`, default 32: width of the timestamp counter, the width counter and the drop counter.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `din`  in  1  pulse input; synchronous to `aclk`, no synchronizer.
- `m_axis_tdata`  out  2*CNTR_WIDTH  record = {width, rise_ts}; width in upper half, timestamp in lower half.
- `m_axis_tvalid`  out  1  head buffer entry valid.
- `m_axis_tready`  in  1  downstream accept.
- `overflow`  out  1  sticky: at least one record dropped since reset.
- `drop_cnt`  out  CNTR_WIDTH  number of dropped records; saturates at all-ones.
- `ts`  out  CNTR_WIDTH  free-running timestamp counter value.

## Operation
- **`ts`:** 0 at reset; increments by 1 every cycle; wraps modulo 2^CNTR_WIDTH.
- **Edge detection:** `din_d` is `din` delayed one cycle; reset value 0.
  - Rise: `din`=1 and `din_d`=0.
  - Fall: `din`=0 and `din_d`=1.
- **States:** IDLE and HIGH. Reset state is IDLE.
  - IDLE, rise → HIGH. Latch `rise_ts` = current `ts`. Set `width` = 1.
  - HIGH, `din`=1 → stay in HIGH. `width` increments, saturating at all-ones.
  - HIGH, fall → IDLE. Complete the record {`width`, `rise_ts`} and attempt a push in the same cycle.
- **Width semantics:** `width` equals the number of cycles `din` was sampled high. A 1-cycle pulse gives width 1.
- **Output buffer:** 2 entries, in order.
  - Pop = `m_axis_tvalid` & `m_axis_tready`.
  - Push is accepted if occupancy < 2, or if occupancy = 2 and a pop occurs in the same cycle.
  - Otherwise the record is discarded: `overflow` ← 1 and `drop_cnt` increments (saturating).
- **AXIS stability:** `m_axis_tdata` shows the head entry. `m_axis_tdata` must stay stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
- **Reset values:** `m_axis_tvalid`=0, `m_axis_tdata`=0, `overflow`=0, `drop_cnt`=0, `ts`=0, buffer empty, state IDLE.
- **Reset mid-pulse:** the partial pulse is discarded. If `din` is still high after reset release, a rise is detected in the first post-reset cycle. Its `rise_ts` = 0 and it is measured from there.

## Timing
- **Record latency:** a record completed in cycle N (first low sample) shows `m_axis_tvalid`=1 in cycle N+1, provided the buffer was empty.
- **Pulse spacing:** back-to-back 1-cycle pulses (1,0,1,0,…) give one record every 2 cycles. The block sustains this without loss when `m_axis_tready`=1.
- **Occupancy:** occupancy and `tvalid` update on the clock edge after push/pop. No combinational path from `m_axis_tready` to `m_axis_tvalid`.
- **`overflow` / `drop_cnt`:** update on the clock edge following the dropped completion.
- **`rise_ts` range:** `rise_ts` uses modulo arithmetic. A pulse spanning a `ts` wrap still reports a correct `width`, because `width` is counted independently of `ts`.

## Test plan
- **Single pulse:** `din` high for cycles 10..14 (5 cycles), `tready`=1 → one record: `rise_ts`=10, `width`=5. `tvalid` high exactly 1 cycle, in cycle 16.
- **Upstream loopback:** drive from `pulse_generator` in continuous mode, start=2, stop=5, period=9 → widths all 3; successive `rise_ts` differ by exactly 10.
- **Backpressure overflow:** 4 pulses of width 2 with `tready`=0 → 2 records buffered, `overflow`=1, `drop_cnt`=2. Raising `tready` delivers the first two pulses in order.
- **Full with simultaneous push/pop:** buffer full; the completion cycle coincides with a pop → record accepted, `drop_cnt` unchanged, order preserved.
- **Wrap:** `CNTR_WIDTH`=8, pulse rises at `ts`=250 with width 10 → `rise_ts`=250, `width`=10. Saturation: a pulse of 300 cycles → `width`=255.
- **Reset mid-pulse:** assert `aresetn`=0 for 2 cycles while in HIGH, with `din` held high → no record for the partial pulse; all outputs at reset values. After release, the next record has `rise_ts`=0.
